// File: rtl/fc_mac_if.sv
// Control, memory-read and PE operand/accumulator signals of fc_mac_sequencer.
// master = sequencer side, slave = memories / PE / consumer side.
interface fc_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 6
);
  logic                    start;
  logic                    busy;
  logic [ADDR_W-1:0]       in_addr;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_WIDTH-1:0]   in_rd_data;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [DATA_WIDTH-1:0]   input_fc;
  logic [DATA_WIDTH-1:0]   iweight_FC;
  logic                    start_FC;
  logic [2*DATA_WIDTH-1:0] acc_in;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    result_valid;
  logic                    result_ready;

  modport master (
    input  start, in_rd_data, w_rd_data, acc_in, result_ready,
    output busy, in_addr, w_addr, input_fc, iweight_FC, start_FC, result, result_valid
  );

  modport slave (
    output start, in_rd_data, w_rd_data, acc_in, result_ready,
    input  busy, in_addr, w_addr, input_fc, iweight_FC, start_FC, result, result_valid
  );
endinterface

// File: rtl/fc_mac_sequencer.sv
// Dot-product sequencer for the FC PE MAC: clear, feed VEC_LEN operand pairs, drain, capture.
// Build option FC_RELU_EN: clamp negative accumulator values (sign bit set) to zero at capture.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle, start_FC pulses, addresses reset to 0
// FEED  | VEC_LEN cycles, address k issued in the k-th cycle
// DRAIN | DRAIN_CYCLES+2 cycles, memory latency + operand reg + PE pipeline; capture on last
// HOLD  | result_valid until result_ready
module fc_mac_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int VEC_LEN      = 64,
  parameter int ADDR_W       = 6,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fc_mac_if.master bus
);
  localparam int                DCNT_W     = $clog2(DRAIN_CYCLES + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VEC_LEN - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [DCNT_W-1:0]       drain_cnt_q;
  logic                    feed_vld_q;
  logic [DATA_WIDTH-1:0]   op_a_q, op_b_q;
  logic [2*DATA_WIDTH-1:0] result_q, capture_val;
  logic                    feed_last, drain_done;

  assign feed_last  = (addr_q == LAST_ADDR);
  assign drain_done = (drain_cnt_q == '0);

`ifdef FC_RELU_EN
  assign capture_val = bus.acc_in[2*DATA_WIDTH-1] ? '0 : bus.acc_in;
`else
  assign capture_val = bus.acc_in;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)        state_d = CLEAR;
      CLEAR:                         state_d = FEED;
      FEED:    if (feed_last)        state_d = DRAIN;
      DRAIN:   if (drain_done)       state_d = HOLD;
      HOLD:    if (bus.result_ready) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      drain_cnt_q <= '0;
      feed_vld_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q    <= state_d;
      // Valid pipe: address issue -> memory data -> operand register.
      feed_vld_q <= (state_q == FEED);
      op_a_q     <= feed_vld_q ? bus.in_rd_data : '0;
      op_b_q     <= feed_vld_q ? bus.w_rd_data  : '0;

      if (state_q == IDLE && bus.start)
        addr_q <= '0;
      else if (state_q == FEED && !feed_last)
        addr_q <= addr_q + ADDR_W'(1);

      if (state_q == FEED)
        drain_cnt_q <= DRAIN_LOAD;
      else if (state_q == DRAIN && !drain_done)
        drain_cnt_q <= drain_cnt_q - DCNT_W'(1);

      if (state_q == DRAIN && drain_done)
        result_q <= capture_val;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.start_FC     = (state_q == CLEAR);
  assign bus.result_valid = (state_q == HOLD);
  assign bus.in_addr      = addr_q;
  assign bus.w_addr       = addr_q;
  assign bus.input_fc     = op_a_q;
  assign bus.iweight_FC   = op_b_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Scoreboard bench for fc_mac_sequencer: default instance under random/directed runs,
// plus a VEC_LEN=1 / DRAIN_CYCLES=0 instance for the minimum-length schedule.
module tb_fc_mac_sequencer;
  localparam int DW = 16, VL = 64, AW = 6, DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_mac_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_a ();
  fc_mac_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_b ();

  fc_mac_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ADDR_W(AW), .DRAIN_CYCLES(DC)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  fc_mac_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(1), .ADDR_W(AW), .DRAIN_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [15:0] in_mem [VL];
  logic [15:0] w_mem  [VL];

  // Synchronous-read memories shared by both instances.
  always @(posedge clk) begin
    bus_a.in_rd_data <= in_mem[bus_a.in_addr];
    bus_a.w_rd_data  <= w_mem[bus_a.w_addr];
    bus_b.in_rd_data <= in_mem[bus_b.in_addr];
    bus_b.w_rd_data  <= w_mem[bus_b.w_addr];
  end

  // PE stand-in: integer sum of products, visible DC cycles after the operand, or a forced value.
  bit          pe_override = 1'b0;
  logic [31:0] pe_val = '0;
  logic [31:0] run_sum = '0;
  logic [31:0] hist[$];
  always @(negedge clk) begin
    if (bus_a.start_FC) run_sum = '0;
    else run_sum = run_sum + 32'(bus_a.input_fc) * 32'(bus_a.iweight_FC);
    hist.push_front(run_sum);
    if (hist.size() > DC + 1) void'(hist.pop_back());
    bus_a.acc_in = pe_override ? pe_val : hist[hist.size() - 1];
  end

  typedef struct { int s; logic [31:0] res; } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FC_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] model_sum();
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < VL; k++) s = s + 32'(in_mem[k]) * 32'(w_mem[k]);
    return s;
  endfunction

  // Monitor: expected schedule derived from the start cycle at the head of the scoreboard.
  always @(negedge clk) begin : monitor
    int rel;
    bit act;
    if (!rst_n) begin
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_start_fc", bus_a.start_FC, 0);
      chk("rst_valid", bus_a.result_valid, 0);
      chk("rst_input_fc", bus_a.input_fc, 0);
      chk("rst_iweight", bus_a.iweight_FC, 0);
      chk("rst_in_addr", bus_a.in_addr, 0);
      chk("rst_w_addr", bus_a.w_addr, 0);
      chk("rst_result", bus_a.result, 0);
    end else begin
      act = (sb.size() > 0);
      rel = act ? cyc - sb[0].s : -1;
      chk("busy", bus_a.busy, 32'(act && rel >= 1));
      chk("start_fc", bus_a.start_FC, 32'(act && rel == 1));
      chk("result_valid", bus_a.result_valid, 32'(act && rel >= VL + 4 + DC));
      if (act && rel >= 2 && rel <= VL + 1) begin
        chk("in_addr", bus_a.in_addr, 32'(rel - 2));
        chk("w_addr", bus_a.w_addr, 32'(rel - 2));
      end
      if (act && rel >= 4 && rel <= VL + 3) begin
        chk("input_fc", bus_a.input_fc, in_mem[rel-4]);
        chk("iweight_fc", bus_a.iweight_FC, w_mem[rel-4]);
      end else begin
        chk("input_fc_zero", bus_a.input_fc, 0);
        chk("iweight_fc_zero", bus_a.iweight_FC, 0);
      end
      if (act && rel >= VL + 4 + DC) begin
        chk("result", bus_a.result, sb[0].res);
        if (bus_a.result_valid && bus_a.result_ready) void'(sb.pop_front());
      end
    end
  end

  // mode 0: ready always high; 1: random ready; 2: ready low for 10 HOLD cycles.
  task automatic do_run(input logic [31:0] exp, input int mode, input bit ign);
    int s, n, rel, held;
    exp_t e;
    n = 0;
    held = 0;
    @(posedge clk); #1;
    bus_a.result_ready = (mode == 0);
    bus_a.start = 1'b1;
    s = cyc;
    e.s = s;
    e.res = exp;
    sb.push_back(e);
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      rel = cyc - s;
      bus_a.start = ign && (rel == 5 || rel == 40 || rel == 70);
      case (mode)
        0: bus_a.result_ready = 1'b1;
        1: bus_a.result_ready = 1'($urandom_range(0, 1));
        default: begin
          bus_a.result_ready = bus_a.result_valid && held >= 10;
          if (bus_a.result_valid) held++;
        end
      endcase
      if (ign && bus_a.result_valid && bus_a.result_ready) bus_a.start = 1'b1;
    end
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_a.result_ready = 1'b0;
    if (sb.size() > 0) begin
      chk("run_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < VL; k++) begin
      in_mem[k] = 16'($urandom_range(1, 65535));
      w_mem[k]  = 16'($urandom_range(1, 65535));
    end
  endtask

  initial begin
    int s, rel;
    bus_a.start = 1'b0; bus_a.result_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.result_ready = 1'b1; bus_b.acc_in = 32'h3F800000;
    fill_random();
    repeat (3) @(posedge clk);
    chk("b_rst_valid", bus_b.result_valid, 0);
    chk("b_rst_busy", bus_b.busy, 0);
    #1 rst_n = 1'b1;

    // Nominal
    for (int k = 0; k < VL; k++) begin in_mem[k] = 16'h3C00; w_mem[k] = 16'h4000; end
    pe_override = 1'b1; pe_val = 32'h43000000;
    do_run(relu(32'h43000000), 0, 1'b0);

    // Ignored starts, then a second identical run
    do_run(relu(32'h43000000), 0, 1'b1);
    do_run(relu(32'h43000000), 0, 1'b0);

    // ReLU case
    pe_val = 32'hC1200000;
    do_run(relu(32'hC1200000), 0, 1'b0);

    // Backpressure with model-derived sums, then random ready
    pe_override = 1'b0;
    fill_random();
    do_run(relu(model_sum()), 2, 1'b0);
    for (int r = 0; r < 4; r++) begin
      fill_random();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_run(relu(model_sum()), 1, 1'b0);
    end

    // Reset mid-FEED
    @(posedge clk); #1;
    bus_a.start = 1'b1;
    s = cyc;
    sb.push_back('{s, relu(model_sum())});
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_a.result_ready = 1'b1;
    do begin @(posedge clk); #1; rel = cyc - s; end while (rel < 30);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    bus_a.result_ready = 1'b0;

    // Minimum length instance
    @(posedge clk); #1;
    bus_b.start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      rel = cyc - s;
      chk("b_start_fc", bus_b.start_FC, 32'(rel == 1));
      chk("b_input_fc", bus_b.input_fc, (rel == 4) ? 32'(in_mem[0]) : 32'h0);
      chk("b_iweight_fc", bus_b.iweight_FC, (rel == 4) ? 32'(w_mem[0]) : 32'h0);
      chk("b_result_valid", bus_b.result_valid, 32'(rel == 5));
      if (rel == 5) chk("b_result", bus_b.result, relu(32'h3F800000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

- Upstream control stage for the fully-connected PE MAC.
- Sequences one dot product:
  - clears the PE accumulator;
  - streams `VEC_LEN` input/weight pairs from two synchronous-read memories onto the PE operand ports;
  - waits out the PE's multiply/add pipeline;
  - captures the PE's 32-bit single-precision accumulator.
- Presents the captured result on a valid/ready output and returns to idle for the next neuron.

## Interface

Parameters:
- `DATA_WIDTH`, 16: operand width driven to the PE.
- `VEC_LEN`, 64: number of MAC terms per dot product (≥1).
- `ADDR_W`, 6: memory address width; `2**ADDR_W ≥ VEC_LEN`.
- `DRAIN_CYCLES`, 4: PE pipeline depth, from last operand to final accumulator value.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a dot product; sampled only in IDLE.
- `busy` output 1: high in every state except IDLE.
- `in_addr` output ADDR_W: input-vector memory read address.
- `w_addr` output ADDR_W: weight memory read address.
- `in_rd_data` input DATA_WIDTH: input memory data, valid one cycle after address.
- `w_rd_data` input DATA_WIDTH: weight memory data, valid one cycle after address.
- `input_fc` output DATA_WIDTH: PE operand A (registered).
- `iweight_FC` output DATA_WIDTH: PE operand B (registered).
- `start_FC` output 1: PE accumulator clear.
- `acc_in` input 2*DATA_WIDTH: PE accumulator output (FP32).
- `result` output 2*DATA_WIDTH: captured dot product.
- `result_valid` output 1: result available.
- `result_ready` input 1: consumer accepts result.

## Operation

FSM states: IDLE, CLEAR, FEED, DRAIN, HOLD.

- **IDLE**
  - `start`=1 → CLEAR.
  - Otherwise stay.
- **CLEAR** (1 cycle)
  - `start_FC`=1; addresses = 0.
  - → FEED.
- **FEED** (exactly `VEC_LEN` cycles)
  - Term counter k = 0..VEC_LEN-1.
  - `in_addr` = `w_addr` = k.
  - → DRAIN after k = VEC_LEN-1.
- **DRAIN** (exactly `DRAIN_CYCLES`+2 cycles)
  - The +2 covers memory read latency and the operand register.
  - On its last cycle, `acc_in` is registered into `result`.
  - → HOLD.
- **HOLD**
  - `result_valid`=1.
  - On `result_valid && result_ready` → IDLE.

Operand path:
- `input_fc`/`iweight_FC` are registered from `in_rd_data`/`w_rd_data`, qualified by a 2-stage valid pipe that follows the FEED issue.
- When the pipe is not valid, the operands are driven 0 (FP +0; adds nothing to the accumulator).
- Exactly `VEC_LEN` non-forced pairs reach the PE, in address order, with no gaps.

Other rules:
- `start_FC` is high only in CLEAR.
- `start` in any state other than IDLE is ignored (no queuing). This includes the HOLD→IDLE handshake cycle.
- `result` is held stable for the whole of HOLD.
- `result_ready` high before `result_valid` is legal. In that case the handshake completes on the first HOLD cycle.
- Addresses hold their last value outside FEED.

Reset (`rst_n` low, any time, including mid-FEED or HOLD):
- FSM → IDLE immediately; counters → 0.
- `busy`, `start_FC`, `result_valid` → 0.
- `input_fc`, `iweight_FC`, `in_addr`, `w_addr`, `result` → 0.
- An interrupted dot product is discarded, and no result is produced.

## Timing

- Cycle 0 is the edge at which `start` is sampled high in IDLE.
- Cycle 1: CLEAR, `start_FC`=1.
- Cycles 2..VEC_LEN+1: FEED; address k issued in cycle 2+k.
- Operand pair k is on `input_fc`/`iweight_FC` in cycle 4+k.
- DRAIN spans cycles VEC_LEN+2..VEC_LEN+3+DRAIN_CYCLES.
- `result_valid` rises in cycle VEC_LEN+4+DRAIN_CYCLES (72 for the defaults).
- Back-to-back throughput: the next `start` is accepted no earlier than 1 cycle after the handshake.

## Configuration

- **`FC_RELU_EN` defined:**
  - At capture, if `acc_in[31]`=1 (negative, including -0), `result` = 32'h00000000.
  - Otherwise `result` = `acc_in`.
- **`FC_RELU_EN` undefined:** `result` = `acc_in` unmodified.
- Timing is identical in both builds.

## Test plan

- **Nominal:** defaults; input memory all 16'h3C00, weight memory all 16'h4000; PE model reports accumulator 32'h43000000.
  - `start_FC` high only in cycle 1.
  - Addresses 0..63 in cycles 2..65.
  - `result`=32'h43000000 with `result_valid` in cycle 72.
- **Backpressure:** `result_ready` low for 10 cycles in HOLD.
  - `result_valid` and `result` stay stable.
  - Handshake on the first ready-high cycle; IDLE next cycle.
- **Ignored start:** `start` pulsed in cycles 5, 40, 70 and on the handshake cycle.
  - No restart, and the schedule is unchanged.
  - After the handshake, a new `start` gives a second identical run.
- **Reset mid-FEED:** `rst_n` low at cycle 30.
  - All outputs at reset values immediately.
  - After release, no `result_valid` occurs without a new `start`.
- **Minimum length:** `VEC_LEN`=1, `DRAIN_CYCLES`=0.
  - Single pair in cycle 4.
  - `result_valid` in cycle 5.
- **ReLU:** PE reports 32'hC1200000.
  - With `FC_RELU_EN`, `result`=0.
  - Without it, `result`=32'hC1200000.
